stream_arb2: RTL and testbench

Two-input round-robin arbiter that merges AXI-stream requesters `b` and `c` onto one shared output stream `a`, with a registered output stage. This is the merge-side counterpart of the stream demux: it sequences and shares a single downstream consumer between two producers. It keeps packets intact by holding the grant until the `last` beat is accepted.

---
 rtl/stream_arb2.sv | 115 +++++++++++
 tb/tb_stream_arb2.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stream_arb2.sv
// Two-input round-robin AXI-stream merge with a registered output stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant from first beat to last beat.
module stream_arb2 #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               b_valid,
  input  logic [DATA_WD-1:0] b_data,
  input  logic               b_last,
  output logic               b_ready,
  input  logic               c_valid,
  input  logic [DATA_WD-1:0] c_data,
  input  logic               c_last,
  output logic               c_ready,
  output logic               a_valid,
  output logic [DATA_WD-1:0] a_data,
  output logic               a_last,
  output logic               a_src,
  input  logic               a_ready
);

  logic               a_valid_q, a_valid_d;
  logic [DATA_WD-1:0] a_data_q, a_data_d;
  logic               a_last_q, a_last_d;
  logic               a_src_q, a_src_d;
  logic               last_gnt_q, last_gnt_d;
  logic               ld, gnt_b, gnt_c;

  assign ld = !a_valid_q || a_ready;

`ifdef STREAM_ARB_PKT_LOCK_EN
  typedef enum logic [1:0] {ARB, HOLD_B, HOLD_C} state_e;
  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (b_ready)      state_d = b_last ? ARB : HOLD_B;
    else if (c_ready) state_d = c_last ? ARB : HOLD_C;
  end
`endif

  // last_gnt_q = 1 means c won last, so b wins the next tie
  always_comb begin
    gnt_b = b_valid && (!c_valid || last_gnt_q);
    gnt_c = c_valid && (!b_valid || !last_gnt_q);
`ifdef STREAM_ARB_PKT_LOCK_EN
    case (state_q)
      HOLD_B: begin
        gnt_b = b_valid;
        gnt_c = 1'b0;
      end
      HOLD_C: begin
        gnt_b = 1'b0;
        gnt_c = c_valid;
      end
      default: ;
    endcase
`endif
  end

  // Readies are masked during reset so nothing is taken while the output is held clear
  assign b_ready = rst_n && ld && gnt_b;
  assign c_ready = rst_n && ld && gnt_c;

  always_comb begin
    a_valid_d  = a_valid_q;
    a_data_d   = a_data_q;
    a_last_d   = a_last_q;
    a_src_d    = a_src_q;
    last_gnt_d = last_gnt_q;
    if (b_ready) begin
      a_valid_d  = 1'b1;
      a_data_d   = b_data;
      a_last_d   = b_last;
      a_src_d    = 1'b0;
      last_gnt_d = 1'b0;
    end else if (c_ready) begin
      a_valid_d  = 1'b1;
      a_data_d   = c_data;
      a_last_d   = c_last;
      a_src_d    = 1'b1;
      last_gnt_d = 1'b1;
    end else if (ld) begin
      a_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid_q  <= 1'b0;
      a_data_q   <= '0;
      a_last_q   <= 1'b0;
      a_src_q    <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      a_valid_q  <= a_valid_d;
      a_data_q   <= a_data_d;
      a_last_q   <= a_last_d;
      a_src_q    <= a_src_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign a_valid = a_valid_q;
  assign a_data  = a_data_q;
  assign a_last  = a_last_q;
  assign a_src   = a_src_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Directed-vector bench for stream_arb2; expectations follow STREAM_ARB_PKT_LOCK_EN.
module tb_stream_arb2;

  logic       clk, rst_n;
  logic       b_valid, b_last, b_ready, c_valid, c_last, c_ready;
  logic [3:0] b_data, c_data, a_data;
  logic       a_valid, a_last, a_src, a_ready;

  int n_vec = 0;
  int n_err = 0;

  stream_arb2 #(.DATA_WD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_last(c_last), .c_ready(c_ready),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_src(a_src),
    .a_ready(a_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       bv; logic [3:0] bd; logic bl;
    logic       cv; logic [3:0] cd; logic cl;
    logic       ar;
    logic       ebr, ecr;
    logic       eav; logic [3:0] ead; logic eal, eas;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic bv, input logic [3:0] bd, input logic bl,
                       input logic cv, input logic [3:0] cd, input logic cl, input logic ar);
    rst_n = r; b_valid = bv; b_data = bd; b_last = bl;
    c_valid = cv; c_data = cd; c_last = cl; a_ready = ar;
  endtask

  // packet-lock sequence state
  logic [3:0] pkt[3];
  int         idx;
  logic [4:0] exp_src;
  logic [3:0] exp_dat[5];

  initial begin
    // {rst, bv,bd,bl, cv,cd,cl, ar, ebr,ecr, eav,ead,eal,eas}
    tbl[0]  = '{0, 1,4'h3,1, 1,4'h4,1, 1, 0,0, 0,4'h0,0,0};  // in reset
    tbl[1]  = '{0, 1,4'h3,1, 1,4'h4,1, 1, 0,0, 0,4'h0,0,0};
    tbl[2]  = '{1, 1,4'h5,1, 1,4'h7,1, 1, 1,0, 1,4'h5,1,0};  // first tie -> b
    tbl[3]  = '{1, 1,4'h5,1, 0,4'h0,0, 1, 1,0, 1,4'h5,1,0};  // single source b
    tbl[4]  = '{1, 0,4'h0,0, 1,4'h9,1, 1, 0,1, 1,4'h9,1,1};  // single source c
    tbl[5]  = '{1, 1,4'h1,1, 1,4'h2,1, 1, 1,0, 1,4'h1,1,0};  // fair share
    tbl[6]  = '{1, 1,4'h1,1, 1,4'h2,1, 1, 0,1, 1,4'h2,1,1};
    tbl[7]  = '{1, 1,4'h1,1, 1,4'h2,1, 1, 1,0, 1,4'h1,1,0};
    tbl[8]  = '{1, 1,4'h1,1, 1,4'h2,1, 1, 0,1, 1,4'h2,1,1};
    tbl[9]  = '{1, 1,4'h3,1, 1,4'h4,1, 0, 0,0, 1,4'h2,1,1};  // backpressure
    tbl[10] = '{1, 1,4'h3,1, 1,4'h4,1, 0, 0,0, 1,4'h2,1,1};
    tbl[11] = '{1, 1,4'h3,1, 1,4'h4,1, 0, 0,0, 1,4'h2,1,1};
    tbl[12] = '{1, 1,4'h3,1, 1,4'h4,1, 0, 0,0, 1,4'h2,1,1};
    tbl[13] = '{1, 1,4'h3,1, 1,4'h4,1, 1, 1,0, 1,4'h3,1,0};  // drain+load same cycle
    tbl[14] = '{1, 0,4'h0,0, 0,4'h0,0, 1, 0,0, 0,4'h3,1,0};  // idle -> bubble

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rst, tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].cv, tbl[i].cd, tbl[i].cl, tbl[i].ar);
      #1;
      chk($sformatf("vec%0d ready", i), {b_ready, c_ready}, {tbl[i].ebr, tbl[i].ecr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d out", i), {a_valid, a_data, a_last, a_src},
          {tbl[i].eav, tbl[i].ead, tbl[i].eal, tbl[i].eas});
      @(negedge clk);
    end

    // Set last_gnt to c so b wins the first tie of the packet
    drive(1, 0, 4'h0, 0, 1, 4'h6, 1, 1);
    @(posedge clk); #1;
    chk("pre-pkt c beat", {a_valid, a_src, a_data}, {1'b1, 1'b1, 4'h6});
    @(negedge clk);

    pkt[0] = 4'hA; pkt[1] = 4'hB; pkt[2] = 4'hC;
`ifdef STREAM_ARB_PKT_LOCK_EN
    exp_src = 5'b11000;  // cycle k -> bit k: 0,0,0,1,1
    exp_dat[0] = 4'hA; exp_dat[1] = 4'hB; exp_dat[2] = 4'hC; exp_dat[3] = 4'h2; exp_dat[4] = 4'h2;
`else
    exp_src = 5'b01010;  // 0,1,0,1,0
    exp_dat[0] = 4'hA; exp_dat[1] = 4'h2; exp_dat[2] = 4'hB; exp_dat[3] = 4'h2; exp_dat[4] = 4'hC;
`endif
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, idx < 3, (idx < 3) ? pkt[idx] : 4'h0, idx == 2, 1, 4'h2, 1, 1);
      #1;
      if (b_ready) idx++;
      @(posedge clk); #1;
      chk($sformatf("pkt cyc%0d", k), {a_valid, a_src, a_data}, {1'b1, exp_src[k], exp_dat[k]});
      @(negedge clk);
    end

    // Mid-packet reset: enter HOLD_B (lock build), then pulse reset
    drive(1, 1, 4'hD, 0, 0, 4'h0, 0, 1);
    @(posedge clk); #1;
    chk("hold_b entry", {a_valid, a_src, a_data, a_last}, {1'b1, 1'b0, 4'hD, 1'b0});
    @(negedge clk);
    drive(0, 0, 4'h0, 0, 0, 4'h0, 0, 1);
    #1;
    chk("async rst out", {a_valid, a_data, a_last, a_src}, 7'd0);
    @(posedge clk); #1;
    chk("rst held out", {a_valid, b_ready, c_ready}, 3'd0);
    @(negedge clk);
    drive(1, 1, 4'hE, 1, 1, 4'hF, 1, 1);
    #1;
    chk("post-rst tie", {b_ready, c_ready}, 2'b10);
    @(posedge clk); #1;
    chk("post-rst out", {a_valid, a_src, a_data}, {1'b1, 1'b0, 4'hE});
    @(negedge clk);
    // c alone must be granted, so the lock is released
    drive(1, 0, 4'h0, 0, 1, 4'h7, 1, 1);
    #1;
    chk("post-rst c only", {b_ready, c_ready}, 2'b01);
    @(posedge clk); #1;
    chk("post-rst c out", {a_valid, a_src, a_data}, {1'b1, 1'b1, 4'h7});
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
